// File: rtl/mat_vec_pkg.sv
// mat_vec_pkg: opcodes, FSM states and field widths shared by the mat_vec_seq blocks
package mat_vec_pkg;
    localparam int OP_W = 4;
    localparam int ARG_W = 12;
    localparam int SIZE_W = 8;
    localparam int CNT_W = 16;
    localparam logic [OP_W-1:0] OP_SET_ROWS = 4'd1;
    localparam logic [OP_W-1:0] OP_SET_COLS = 4'd2;
    localparam logic [OP_W-1:0] OP_START = 4'd3;
    localparam logic [OP_W-1:0] OP_WRITE_VEC = 4'd4;
    localparam logic [OP_W-1:0] OP_WRITE_MAT = 4'd5;
    localparam logic [OP_W-1:0] OP_READ_RESULT = 4'd6;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_VEC,
        S_LOAD_MAT,
        S_FETCH,
        S_CAL,
        S_DRAIN,
        S_READ
    } state_t;
endpackage

// File: rtl/mat_vec_seq_if.sv
// mat_vec_seq_if: command/response handshake bus between a host and mat_vec_seq
interface mat_vec_seq_if #(parameter int WORD_SIZE = 16);
    logic cmd_valid;
    logic cmd_ready;
    logic [WORD_SIZE-1:0] cmd_data;
    logic rsp_valid;
    logic rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;
    logic err;
    modport master (output cmd_valid, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data, err);
    modport slave (input cmd_valid, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data, err);
endinterface

// File: rtl/mat_vec_addr_gen.sv
// mat_vec_addr_gen: per-PE matrix row addresses for fetch step k, unused columns read the zero word
module mat_vec_addr_gen
    import mat_vec_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int PE_NUMBER = 64,
    parameter logic [ADDR_SIZE-1:0] MEM_HEAD_ADDR = 'h00f,
    parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = '1
) (
    input logic [CNT_W-1:0] k,
    input logic [SIZE_W-1:0] rows,
    input logic [SIZE_W-1:0] cols,
    input logic fetch,
    output logic [PE_NUMBER*ADDR_SIZE-1:0] pe_addr
);
    logic [ADDR_SIZE-1:0] row_base;
    assign row_base = MEM_HEAD_ADDR + ADDR_SIZE'(rows) + ADDR_SIZE'(k) * ADDR_SIZE'(cols);
    genvar i;
    generate
        for (i = 0; i < PE_NUMBER; i++) begin : g_pe
            assign pe_addr[i*ADDR_SIZE +: ADDR_SIZE] =
                (fetch && (i < int'(cols))) ? row_base + ADDR_SIZE'(i) : ZERO_POINT_ADDR;
        end
    endgenerate
endmodule

// File: rtl/mat_vec_seq.sv
// mat_vec_seq: command-driven sequencer loading a vector/matrix, running the PE array and returning results
module mat_vec_seq
    import mat_vec_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 16,
    parameter int PE_NUMBER = 64,
    parameter logic [ADDR_SIZE-1:0] MEM_HEAD_ADDR = 'h00f,
    parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = '1
) (
    input logic clk,
    input logic rst,
    mat_vec_seq_if.slave bus,
    output logic mem_w_en,
    output logic [ADDR_SIZE-1:0] mem_w_addr,
    output logic [WORD_SIZE-1:0] mem_w_data,
    output logic [ADDR_SIZE-1:0] mem_r_addr,
    input logic [WORD_SIZE-1:0] mem_r_data,
    output logic [ADDR_SIZE-1:0] vec_addr,
    output logic [PE_NUMBER*ADDR_SIZE-1:0] pe_addr,
    output logic array_clear,
    output logic array_read,
    input logic [WORD_SIZE-1:0] array_res,
    output logic busy
);
    state_t state;
    logic [SIZE_W-1:0] rows, cols;
    logic [CNT_W-1:0] cnt, cnt_nx, n_rows, n_cols;
    logic pend, rsp_valid_q, err_q, clear_q, last, fire, sizes_ok, arg_ok;
    logic [ADDR_SIZE-1:0] r_addr, cnt_a, mat_base, res_base;
    logic [OP_W-1:0] op;
    logic [SIZE_W-1:0] arg;

    assign op = bus.cmd_data[ARG_W +: OP_W];
    assign arg = bus.cmd_data[SIZE_W-1:0];
    assign fire = bus.cmd_valid && bus.cmd_ready;
    assign sizes_ok = (rows != '0) && (cols != '0);
    assign arg_ok = (arg != '0) && (arg <= SIZE_W'(PE_NUMBER));
    assign n_rows = CNT_W'(rows);
    assign n_cols = CNT_W'(cols);
    assign cnt_nx = cnt + CNT_W'(1);
    assign cnt_a = ADDR_SIZE'(cnt);
    assign mat_base = MEM_HEAD_ADDR + ADDR_SIZE'(rows);
    assign res_base = mat_base + ADDR_SIZE'(rows) * ADDR_SIZE'(cols);
    assign last = (state == S_LOAD_VEC || state == S_FETCH) ? cnt == n_rows - CNT_W'(1) :
                  (state == S_LOAD_MAT) ? cnt == n_rows * n_cols - CNT_W'(1) :
                  (state == S_CAL) ? cnt == n_rows + n_cols - CNT_W'(2) :
                  cnt == n_cols - CNT_W'(1);

    assign bus.cmd_ready = (state == S_IDLE) || (state == S_LOAD_VEC) || (state == S_LOAD_MAT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data = mem_r_data;
    assign bus.err = err_q;
    assign busy = state != S_IDLE;
    assign array_clear = clear_q;
    assign array_read = !rst && state == S_DRAIN;
    assign mem_w_en = !rst && ((fire && (state == S_LOAD_VEC || state == S_LOAD_MAT)) || state == S_DRAIN);
    assign mem_w_addr = (state == S_LOAD_VEC) ? MEM_HEAD_ADDR + cnt_a :
                        (state == S_LOAD_MAT) ? mat_base + cnt_a :
                        (state == S_DRAIN) ? res_base + cnt_a : ZERO_POINT_ADDR;
    assign mem_w_data = (state == S_DRAIN) ? array_res : bus.cmd_data;
    assign mem_r_addr = r_addr;
    assign vec_addr = (state == S_FETCH) ? MEM_HEAD_ADDR + cnt_a : ZERO_POINT_ADDR;

    mat_vec_addr_gen #(
        .ADDR_SIZE(ADDR_SIZE),
        .PE_NUMBER(PE_NUMBER),
        .MEM_HEAD_ADDR(MEM_HEAD_ADDR),
        .ZERO_POINT_ADDR(ZERO_POINT_ADDR)
    ) u_addr_gen (
        .k(cnt),
        .rows(rows),
        .cols(cols),
        .fetch(state == S_FETCH),
        .pe_addr(pe_addr)
    );

    // Sequencer FSM: command decode, per-phase step counter, result read-out handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rows <= '0;
            cols <= '0;
            cnt <= '0;
            pend <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q <= 1'b0;
            clear_q <= 1'b0;
            r_addr <= ZERO_POINT_ADDR;
        end else begin
            err_q <= 1'b0;
            clear_q <= 1'b0;
            case (state)
                S_IDLE: if (fire) begin
                    cnt <= '0;
                    case (op)
                        OP_SET_ROWS: if (arg_ok) rows <= arg; else err_q <= 1'b1;
                        OP_SET_COLS: if (arg_ok) cols <= arg; else err_q <= 1'b1;
                        OP_START: if (sizes_ok) begin
                            state <= S_FETCH;
                            clear_q <= 1'b1;
                        end else err_q <= 1'b1;
                        OP_WRITE_VEC: if (rows != '0) state <= S_LOAD_VEC; else err_q <= 1'b1;
                        OP_WRITE_MAT: if (sizes_ok) state <= S_LOAD_MAT; else err_q <= 1'b1;
                        OP_READ_RESULT: if (sizes_ok) begin
                            state <= S_READ;
                            r_addr <= res_base;
                            pend <= 1'b1;
                        end else err_q <= 1'b1;
                        default: err_q <= 1'b1;
                    endcase
                end
                S_LOAD_VEC, S_LOAD_MAT: if (fire) begin
                    cnt <= last ? '0 : cnt_nx;
                    if (last) state <= S_IDLE;
                end
                S_FETCH, S_CAL, S_DRAIN: begin
                    cnt <= last ? '0 : cnt_nx;
                    if (last) state <= (state == S_FETCH) ? S_CAL : (state == S_CAL) ? S_DRAIN : S_IDLE;
                end
                S_READ: if (pend) begin
                    pend <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end else if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cnt <= last ? '0 : cnt_nx;
                    r_addr <= last ? ZERO_POINT_ADDR : r_addr + ADDR_SIZE'(1);
                    pend <= !last;
                    if (last) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_vec_seq.sv
// tb_mat_vec_seq: directed table-driven and sequence checks for mat_vec_seq
module tb_mat_vec_seq;
    localparam int AW = 10;
    localparam int WW = 16;
    localparam int PN = 64;
    localparam logic [AW-1:0] ZERO = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_w_en, array_clear, array_read, busy;
    logic [AW-1:0] mem_w_addr, mem_r_addr, vec_addr;
    logic [WW-1:0] mem_w_data, mem_r_data, array_res;
    logic [PN*AW-1:0] pe_addr;
    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic [7:0] rd_cnt = '0;
    logic [AW-1:0] wa [$];
    logic [WW-1:0] wd [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] cmd;
        logic exp_err;
    } vec_t;
    vec_t tbl [12];

    mat_vec_seq_if #(.WORD_SIZE(WW)) bus ();

    mat_vec_seq dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .mem_w_en(mem_w_en),
        .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data),
        .mem_r_addr(mem_r_addr),
        .mem_r_data(mem_r_data),
        .vec_addr(vec_addr),
        .pe_addr(pe_addr),
        .array_clear(array_clear),
        .array_read(array_read),
        .array_res(array_res),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign array_res = 16'h00A0 + 16'(rd_cnt);

    always @(posedge clk) begin
        if (mem_w_en) begin
            mem[mem_w_addr] <= mem_w_data;
            wa.push_back(mem_w_addr);
            wd.push_back(mem_w_data);
        end
        mem_r_data <= mem[mem_r_addr];
        rd_cnt <= array_clear ? 8'd0 : array_read ? rd_cnt + 8'd1 : rd_cnt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = w;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("cmd_ready_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (!bus.rsp_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rsp_valid_timeout", 32'(t < 20), 32'd1);
    endtask

    function automatic logic [AW-1:0] pe(input int i);
        return pe_addr[i*AW +: AW];
    endfunction

    initial begin
        int n;
        tbl[0] = '{16'h3000, 1'b1};
        tbl[1] = '{16'h6000, 1'b1};
        tbl[2] = '{16'h1000, 1'b1};
        tbl[3] = '{16'h1040, 1'b0};
        tbl[4] = '{16'h1003, 1'b0};
        tbl[5] = '{16'h2000, 1'b1};
        tbl[6] = '{16'h2041, 1'b1};
        tbl[7] = '{16'hF000, 1'b1};
        tbl[8] = '{16'h0000, 1'b1};
        tbl[9] = '{16'h2002, 1'b0};
        tbl[10] = '{16'h2041, 1'b1};
        tbl[11] = '{16'h2000, 1'b1};
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_vec_addr", 32'(vec_addr), 32'(ZERO));
        chk("rst_pe0", 32'(pe(0)), 32'(ZERO));

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].cmd);
            chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
        end

        wa.delete();
        wd.delete();
        send(16'h4000);
        chk("vec_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) send(16'(5 + i));
        chk("vec_cnt", 32'(wa.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("vec_addr%0d", i), 32'(wa[i]), 32'h00f + 32'(i));
            chk($sformatf("vec_data%0d", i), 32'(wd[i]), 32'd5 + 32'(i));
        end
        chk("vec_idle", 32'(busy), 32'd0);

        wa.delete();
        wd.delete();
        send(16'h5000);
        for (int i = 1; i <= 6; i++) send(16'(i));
        chk("mat_cnt", 32'(wa.size()), 32'd6);
        chk("mat_first", 32'(wa[0]), 32'h012);
        chk("mat_last_addr", 32'(wa[5]), 32'h017);
        chk("mat_last_data", 32'(wd[5]), 32'd6);
        chk("mat_idle", 32'(busy), 32'd0);

        wa.delete();
        wd.delete();
        send(16'h3000);
        chk("f0_clear", 32'(array_clear), 32'd1);
        chk("f0_vec", 32'(vec_addr), 32'h00f);
        chk("f0_pe0", 32'(pe(0)), 32'h012);
        @(posedge clk); #1;
        chk("f1_clear", 32'(array_clear), 32'd0);
        chk("f1_vec", 32'(vec_addr), 32'h010);
        chk("f1_pe0", 32'(pe(0)), 32'h014);
        chk("f1_pe1", 32'(pe(1)), 32'h015);
        chk("f1_pe2", 32'(pe(2)), 32'(ZERO));
        @(posedge clk); #1;
        chk("f2_pe1", 32'(pe(1)), 32'h017);
        n = 0;
        @(posedge clk); #1;
        chk("cal_vec", 32'(vec_addr), 32'(ZERO));
        while (!array_read && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("cal_len", 32'(n), 32'd4);
        chk("d0_addr", 32'(mem_w_addr), 32'h018);
        chk("d0_data", 32'(mem_w_data), 32'h0A0);
        @(posedge clk); #1;
        chk("d1_read", 32'(array_read), 32'd1);
        chk("d1_addr", 32'(mem_w_addr), 32'h019);
        @(posedge clk); #1;
        chk("drain_idle", 32'(busy), 32'd0);
        chk("drain_writes", 32'(wa.size()), 32'd2);

        send(16'h6000);
        wait_rsp();
        chk("r0_data", 32'(bus.rsp_data), 32'h0A0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("r0_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("r0_hold_data", 32'(bus.rsp_data), 32'h0A0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        wait_rsp();
        chk("r1_data", 32'(bus.rsp_data), 32'h0A1);
        @(posedge clk); #1;
        chk("read_idle", 32'(busy), 32'd0);
        chk("read_done_valid", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;

        send(16'h3000);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cal", 32'(busy && vec_addr == ZERO && !array_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        wa.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_writes", 32'(wa.size()), 32'd0);
        send(16'h3000);
        chk("start_unset_err", 32'(bus.err), 32'd1);
        chk("start_unset_busy", 32'(busy), 32'd0);

        send(16'h1001);
        send(16'h2001);
        send(16'h3000);
        n = 0;
        while (!array_read && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain_pre_wen", 32'(mem_w_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("drain_rst_wen", 32'(mem_w_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("drain_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
